ctrl_pipe_gen: RTL and testbench

//  Parametrised control-word pipeline from decode through STAGES back-end stages (E, M, W, ...).

---
 rtl/ctrl_pipe_gen.sv | 67 ++++++
 tb/tb_ctrl_pipe_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_gen.sv
// ctrl_pipe_gen: control-word pipeline with per-stage stall/flush and mult/div hazard tracking
module ctrl_pipe_gen #(
    parameter int CW        = 12,
    parameter int STAGES    = 3,
    parameter int MD_CYCLES = 4,
    parameter int MD_BIT    = 10,
    parameter int HL_BIT    = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW-1:0]        ctl_d,
    input  logic                 valid_d,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    output logic [STAGES*CW-1:0] ctl_q,
    output logic [STAGES-1:0]    valid_q,
    output logic                 stall_req,
    output logic                 md_busy,
    output logic                 md_done
);
    localparam int CTW = $clog2(MD_CYCLES + 1);
    logic [STAGES-1:0][CW-1:0] stageWord;
    logic [STAGES-1:0]         effStall;
    logic [CTW-1:0]            mdCount;
    logic                      mdStart;
    for (genvar k = 0; k < STAGES; k++) begin : g_es
        assign effStall[k] = |stall[STAGES-1:k];
    end
    assign ctl_q     = stageWord;
    assign md_busy   = mdCount != '0;
    assign stall_req = valid_d & (ctl_d[MD_BIT] | ctl_d[HL_BIT]) & md_busy;
    assign mdStart   = valid_d & ctl_d[MD_BIT] & ~flush[0] & ~effStall[0] & ~stall_req;
    // stage registers: flush beats hold; a stage whose upstream holds takes a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stageWord <= '0;
            valid_q   <= '0;
        end else begin
            if (flush[0] | (~effStall[0] & stall_req)) begin
                stageWord[0] <= '0;
                valid_q[0]   <= 1'b0;
            end else if (!effStall[0]) begin
                stageWord[0] <= ctl_d;
                valid_q[0]   <= valid_d;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (flush[k] | (~effStall[k] & effStall[k-1])) begin
                    stageWord[k] <= '0;
                    valid_q[k]   <= 1'b0;
                end else if (!effStall[k]) begin
                    stageWord[k] <= stageWord[k-1];
                    valid_q[k]   <= valid_q[k-1];
                end
            end
        end
    end
    // mult/div occupancy counter and completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdCount <= '0;
            md_done <= 1'b0;
        end else begin
            mdCount <= mdStart ? CTW'(MD_CYCLES) : (md_busy ? mdCount - CTW'(1) : mdCount);
            md_done <= mdCount == CTW'(1);
        end
    end
endmodule

// File: tb/tb_ctrl_pipe_gen.sv
// tb_ctrl_pipe_gen: directed scoreboard bench for ctrl_pipe_gen
module tb_ctrl_pipe_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] ctl_d;
    logic        valid_d;
    logic [2:0]  stall, flush;
    logic [35:0] ctl_q;
    logic [2:0]  valid_q;
    logic        stall_req, md_busy, md_done;
    int checks = 0;
    int errors = 0;
    logic [11:0] expQ[$];
    logic [11:0] expW;

    ctrl_pipe_gen dut (
        .clk(clk), .reset(reset), .ctl_d(ctl_d), .valid_d(valid_d),
        .stall(stall), .flush(flush), .ctl_q(ctl_q), .valid_q(valid_q),
        .stall_req(stall_req), .md_busy(md_busy), .md_done(md_done)
    );

    always #5 clk = ~clk;

    // monitor: every valid word leaving the last stage must match the next expected word
    always @(negedge clk) begin
        if (reset && valid_q[2]) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL stage2_unexpected got %h required none", ctl_q[35:24]);
            end else begin
                expW = expQ.pop_front();
                if (ctl_q[35:24] !== expW) begin
                    errors++;
                    $display("FAIL stage2_word got %h required %h", ctl_q[35:24], expW);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    initial begin
        reset = 1'b1; ctl_d = '0; valid_d = 1'b0; stall = '0; flush = '0;
        #2 reset = 1'b0;
        repeat (2) tick();
        chk("rst_ctl", ctl_q, 36'h0);
        chk("rst_valid", 36'(valid_q), 36'h0);
        chk("rst_md", {md_busy, md_done, stall_req}, 36'h0);
        reset = 1'b1;
        // flow latency
        ctl_d = 12'h0A5; valid_d = 1'b1; expQ.push_back(12'h0A5);
        tick();
        chk("flow_s0", {ctl_q[11:0], 24'(valid_q[0])}, {12'h0A5, 24'h1});
        ctl_d = '0; valid_d = 1'b0;
        tick();
        chk("flow_s1", {ctl_q[23:12], 24'(valid_q)}, {12'h0A5, 24'h2});
        tick();
        chk("flow_s2_valid", 36'(valid_q), 36'h4);
        // stall in stage 1
        ctl_d = 12'h0FF; valid_d = 1'b1; expQ.push_back(12'h0FF); tick();
        ctl_d = 12'h011; expQ.push_back(12'h011); tick();
        ctl_d = 12'h022; expQ.push_back(12'h022); tick();
        stall = 3'b010; valid_d = 1'b0; ctl_d = '0;
        tick();
        chk("stall_words", ctl_q, {12'h000, 12'h011, 12'h022});
        chk("stall_valid", 36'(valid_q), 36'h3);
        stall = '0;
        tick();
        chk("stall_release", 36'(valid_q), 36'h6);
        repeat (2) tick();
        // flush beats stall at stage 0
        ctl_d = 12'h044; valid_d = 1'b1; tick();
        flush = 3'b001; stall = 3'b001; ctl_d = 12'h055;
        tick();
        chk("flush_s0", {ctl_q[11:0], 24'(valid_q[1:0])}, 36'h0);
        flush = '0; stall = '0; ctl_d = 12'h066; tick();
        flush = 3'b010; valid_d = 1'b0; ctl_d = '0;
        tick();
        chk("flush_s1_all", {ctl_q[35:12], 12'(valid_q)}, 36'h0);
        flush = '0;
        repeat (2) tick();
        // mult/div issue followed by mfhi
        ctl_d = 12'h400; valid_d = 1'b1; expQ.push_back(12'h400);
        tick();
        chk("md_busy_start", 36'(md_busy), 36'h1);
        ctl_d = 12'h800; expQ.push_back(12'h800);
        #1;
        chk("md_stall_req", 36'(stall_req), 36'h1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("md_busy_hold", {33'(md_busy), valid_q[0], stall_req, md_done}, {33'h1, 3'b010});
        end
        tick();
        chk("md_finish", {33'(md_busy), valid_q[0], stall_req, md_done}, {33'h0, 3'b001});
        tick();
        chk("md_mfhi_load", {ctl_q[11:0], 23'(valid_q[0]), md_done}, {12'h800, 23'h1, 1'b0});
        ctl_d = 12'h400; valid_d = 1'b0;
        tick();
        chk("md_nostart_hl", 36'(md_busy), 36'h0);
        tick();
        chk("md_nostart_invalid", 36'(md_busy), 36'h0);
        ctl_d = '0;
        repeat (3) tick();
        // reset in the middle of a mult/div
        ctl_d = 12'h400; valid_d = 1'b1; expQ.push_back(12'h400);
        tick();
        ctl_d = 12'h800; valid_d = 1'b0;
        #1;
        chk("md_invalid_no_req", {35'(md_busy), stall_req}, {35'h1, 1'b0});
        repeat (2) tick();
        chk("md_busy_mid", 36'(md_busy), 36'h1);
        #6 reset = 1'b0;
        #1;
        chk("rst_async_ctl", ctl_q, 36'h0);
        chk("rst_async_md", {33'(valid_q), md_busy, md_done, stall_req}, 36'h0);
        tick();
        reset = 1'b1; ctl_d = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_no_done", {34'(md_busy), md_done}, 36'h0);
        end
        chk("scoreboard_empty", 36'(expQ.size()), 36'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
